// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver: segment width, the
// active-low hex pattern table and the digit-index width helper.
package ss_pkg;

   localparam int unsigned SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

   // Active-low patterns, bit0 = a ... bit6 = g, indexed by hex value.
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic int unsigned idx_width(int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ss_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module ss_hex_decode
   import ss_pkg::*;
(
   input  logic [3:0]       nibble_i,
   output logic [SEG_W-1:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/ss_scan_driver.sv
// Time-multiplexed, double-buffered N-digit common-anode seven-segment driver.
// Define SS_SCAN_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module ss_scan_driver
   import ss_pkg::*;
#(
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] value_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   input  logic                  load,
   input  logic                  enable,
   output logic [SEG_W-1:0]      seg_out,
   output logic                  dp_out,
   output logic [N_DIGITS-1:0]   an_out,
   output logic                  frame_done
);

   localparam int unsigned IdxW = idx_width(N_DIGITS);
   localparam int unsigned CntW = $clog2(TICK_DIV);
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIGITS - 1);

   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [IdxW-1:0]            idx_q, idx_d;
   logic [N_DIGITS-1:0][3:0]   stg_val_q, stg_val_d, shd_val_q, shd_val_d;
   logic [N_DIGITS-1:0]        stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
   logic [N_DIGITS-1:0]        stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
   logic                       pending_q, pending_d;
   logic [SEG_W-1:0]           seg_q, seg_d;
   logic                       dp_q, dp_d;
   logic [N_DIGITS-1:0]        an_q, an_d;
   logic                       fd_q, fd_d;

   logic                       tick_end, frame_end;
   logic [3:0]                 cur_nib;
   logic [SEG_W-1:0]           cur_seg;
   logic [N_DIGITS-1:0]        auto_blank;
   logic                       cur_blank;

   assign tick_end  = (cnt_q == CntLast);
   assign frame_end = tick_end && (idx_q == IdxLast);

   assign cur_nib   = shd_val_q[idx_q];
   assign cur_blank = shd_blank_q[idx_q] | auto_blank[idx_q];

   ss_hex_decode u_dec (
      .nibble_i (cur_nib),
      .seg_o    (cur_seg)
   );

`ifdef SS_SCAN_LEADING_ZERO_BLANK_EN
   logic zero_run;

   // Walk down from the top digit; a digit is dark while everything above and including it is zero.
   always_comb begin
      auto_blank = '0;
      zero_run   = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
         zero_run      = zero_run && (shd_val_q[i] == 4'h0) && !shd_dp_q[i];
         auto_blank[i] = zero_run;
      end
   end
`else
   assign auto_blank = '0;
`endif

   always_comb begin
      cnt_d       = tick_end ? '0 : cnt_q + 1'b1;
      idx_d       = idx_q;
      if (tick_end) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end

      shd_val_d   = shd_val_q;
      shd_dp_d    = shd_dp_q;
      shd_blank_d = shd_blank_q;
      stg_val_d   = stg_val_q;
      stg_dp_d    = stg_dp_q;
      stg_blank_d = stg_blank_q;
      pending_d   = pending_q;

      // Shadow copies the old staging before a same-cycle load overwrites it.
      if (frame_end && pending_q) begin
         shd_val_d   = stg_val_q;
         shd_dp_d    = stg_dp_q;
         shd_blank_d = stg_blank_q;
         pending_d   = 1'b0;
      end
      if (load) begin
         stg_val_d   = value_in;
         stg_dp_d    = dp_in;
         stg_blank_d = blank_in;
         pending_d   = 1'b1;
      end

      fd_d  = frame_end;
      seg_d = cur_blank ? SEG_OFF : cur_seg;
      dp_d  = cur_blank ? 1'b1 : ~shd_dp_q[idx_q];
      an_d  = '1;
      if (enable && !cur_blank) begin
         an_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         stg_val_q   <= '0;
         stg_dp_q    <= '0;
         stg_blank_q <= '0;
         shd_val_q   <= '0;
         shd_dp_q    <= '0;
         shd_blank_q <= '0;
         pending_q   <= 1'b0;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b1;
         an_q        <= '1;
         fd_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         stg_val_q   <= stg_val_d;
         stg_dp_q    <= stg_dp_d;
         stg_blank_q <= stg_blank_d;
         shd_val_q   <= shd_val_d;
         shd_dp_q    <= shd_dp_d;
         shd_blank_q <= shd_blank_d;
         pending_q   <= pending_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
         fd_q        <= fd_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Randomized self-checking bench for ss_scan_driver (4 digits, 4-cycle dwell)
// against a time-arithmetic display model.
module tb_ss_scan_driver;

   localparam int N  = 4;
   localparam int TD = 4;
   localparam int FR = N * TD;

   localparam logic [6:0] PAT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   value_in = '0;
   logic [3:0]    dp_in = '0;
   logic [3:0]    blank_in = '0;
   logic          load = 1'b0;
   logic          enable = 1'b1;
   logic [6:0]    seg_out;
   logic          dp_out;
   logic [3:0]    an_out;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   // Model: cyc counts edges since reset release; digit and frame follow from it.
   int            cyc = 0;
   logic [3:0]    m_stg_val [N];
   logic [3:0]    m_shd_val [N];
   logic          m_stg_dp [N], m_shd_dp [N], m_stg_bl [N], m_shd_bl [N];
   logic          m_pend;
   logic [12:0]   exp_v;

   ss_scan_driver #(.N_DIGITS(N), .TICK_DIV(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .load       (load),
      .enable     (enable),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic bit lz_blank(int d);
`ifdef SS_SCAN_LEADING_ZERO_BLANK_EN
      if (d == 0) return 1'b0;
      for (int j = d; j < N; j++) begin
         if (m_shd_val[j] != 4'h0 || m_shd_dp[j]) return 1'b0;
      end
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [12:0] got_v();
      return {seg_out, dp_out, an_out, frame_done};
   endfunction

   // Advance one clock, predicting the outputs that this edge registers.
   task automatic tick();
      int         d;
      bit         bnd, blk;
      logic [3:0] a;
      d   = (cyc / TD) % N;
      bnd = (cyc % FR) == FR - 1;
      if (rst) begin
         exp_v = {7'h7F, 1'b1, 4'hF, 1'b0};
         for (int i = 0; i < N; i++) begin
            m_stg_val[i] = 0; m_shd_val[i] = 0;
            m_stg_dp[i] = 0; m_shd_dp[i] = 0; m_stg_bl[i] = 0; m_shd_bl[i] = 0;
         end
         m_pend = 0;
         cyc    = 0;
      end else begin
         blk = m_shd_bl[d] || lz_blank(d);
         a   = 4'hF;
         if (enable && !blk) a[d] = 1'b0;
         exp_v = {blk ? 7'h7F : PAT[m_shd_val[d]], blk ? 1'b1 : ~m_shd_dp[d], a, bnd};
         if (bnd && m_pend) begin
            m_shd_val = m_stg_val; m_shd_dp = m_stg_dp; m_shd_bl = m_stg_bl;
            m_pend = 0;
         end
         if (load) begin
            for (int i = 0; i < N; i++) begin
               m_stg_val[i] = value_in[4*i +: 4];
               m_stg_dp[i]  = dp_in[i];
               m_stg_bl[i]  = blank_in[i];
            end
            m_pend = 1;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (got_v() !== 13'({7'h7F, 1'b1, 4'hF, 1'b0})) begin
            errors++;
            $display("FAIL reset got=%h want=%h", got_v(), {7'h7F, 1'b1, 4'hF, 1'b0});
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (an_out !== 4'b1110 || seg_out !== 7'h40 || got_v() !== exp_v) begin
         errors++;
         $display("FAIL first_digit got=%h want an=1110 seg=40 (%h)", got_v(), exp_v);
      end
   endtask

   task automatic test_scan();
      int pulses = 0;
      value_in = 16'h1234; dp_in = '0; blank_in = '0; enable = 1'b1;
      load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 2 * FR; i++) begin
         tick();
         checks++;
         if (got_v() !== exp_v) begin
            errors++;
            $display("FAIL scan cyc=%0d got=%h want=%h", cyc, got_v(), exp_v);
         end
      end
      for (int i = 0; i < 4 * FR; i++) begin
         tick();
         pulses += int'(frame_done);
         checks++;
         if (got_v() !== exp_v) begin
            errors++;
            $display("FAIL scan2 cyc=%0d got=%h want=%h", cyc, got_v(), exp_v);
         end
      end
      checks++;
      if (pulses !== 4) begin
         errors++;
         $display("FAIL frame_rate got=%0d want=4", pulses);
      end
   endtask

   task automatic test_tear();
      while (cyc % FR != 5) tick();
      value_in = 16'hAAAA; load = 1'b1; tick(); load = 1'b0;
      tick();
      value_in = 16'h5555; load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 2 * FR + 4; i++) begin
         tick();
         checks++;
         if (got_v() !== exp_v) begin
            errors++;
            $display("FAIL tear cyc=%0d got=%h want=%h", cyc, got_v(), exp_v);
         end
         if (!an_out[0] && seg_out !== 7'b0010010 && i > FR) begin
            errors++;
            $display("FAIL tear_five got=%h want=12", seg_out);
         end
      end
   endtask

   task automatic test_blank_dp();
      int pulses = 0;
      value_in = 16'h1234; blank_in = 4'b0100; dp_in = 4'b0001;
      load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 3 * FR; i++) begin
         enable = (i < 2 * FR) ? 1'b1 : 1'b0;
         tick();
         if (!enable) pulses += int'(frame_done);
         checks++;
         if (got_v() !== exp_v) begin
            errors++;
            $display("FAIL blank_dp cyc=%0d en=%0b got=%h want=%h", cyc, enable, got_v(), exp_v);
         end
      end
      checks++;
      if (pulses !== 1 || an_out !== 4'hF) begin
         errors++;
         $display("FAIL disabled pulses=%0d an=%b want 1 and 1111", pulses, an_out);
      end
      enable = 1'b1; blank_in = '0; dp_in = '0;
   endtask

   task automatic test_boundary_load();
      while (cyc % FR != 4) tick();
      value_in = 16'h9876; load = 1'b1; tick(); load = 1'b0;
      while (cyc % FR != FR - 1) tick();
      value_in = 16'hBEEF; load = 1'b1; tick(); load = 1'b0;
      tick();
      checks++;
      if (seg_out !== 7'h02 || an_out !== 4'b1110 || got_v() !== exp_v) begin
         errors++;
         $display("FAIL bnd_old got=%h want seg=02 an=1110", got_v());
      end
      for (int i = 0; i < FR; i++) begin
         tick();
         checks++;
         if (got_v() !== exp_v) begin
            errors++;
            $display("FAIL bnd cyc=%0d got=%h want=%h", cyc, got_v(), exp_v);
         end
      end
      checks++;
      if (seg_out !== 7'h0E || an_out !== 4'b1110) begin
         errors++;
         $display("FAIL bnd_new got=%h want seg=0e an=1110", got_v());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         value_in = 16'($urandom);
         dp_in    = 4'($urandom);
         blank_in = 4'($urandom) & 4'($urandom);
         load     = ($urandom_range(0, 7) == 0);
         enable   = ($urandom_range(0, 3) != 0);
         tick();
         load = 1'b0;
         checks++;
         if (got_v() !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_v(), exp_v);
         end
      end
      enable = 1'b1; blank_in = '0; dp_in = '0;
   endtask

   task automatic test_mid_reset();
      while (cyc % FR != 3) tick();
      value_in = 16'hC0DE; load = 1'b1; tick(); load = 1'b0;
      tick();
      rst = 1'b1; tick();
      checks++;
      if (got_v() !== 13'({7'h7F, 1'b1, 4'hF, 1'b0})) begin
         errors++;
         $display("FAIL mid_reset got=%h want=%h", got_v(), {7'h7F, 1'b1, 4'hF, 1'b0});
      end
      rst = 1'b0;
      for (int i = 0; i < 2 * FR; i++) begin
         tick();
         checks++;
         if (got_v() !== exp_v || (!an_out[3] && seg_out !== 7'h40)) begin
            errors++;
            $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, got_v(), exp_v);
         end
      end
   endtask

`ifdef SS_SCAN_LEADING_ZERO_BLANK_EN
   task automatic test_lz();
      logic [15:0] vals [2];
      vals[0] = 16'h0070;
      vals[1] = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         value_in = vals[k]; load = 1'b1; tick(); load = 1'b0;
         for (int i = 0; i < 2 * FR; i++) begin
            tick();
            checks++;
            if (got_v() !== exp_v) begin
               errors++;
               $display("FAIL lz val=%h cyc=%0d got=%h want=%h", vals[k], cyc, got_v(), exp_v);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_tear();
      test_blank_dp();
      test_boundary_load();
      test_random();
      test_mid_reset();
`ifdef SS_SCAN_LEADING_ZERO_BLANK_EN
      test_lz();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display. Generalised successor of the single-digit hex-to-segment decoder.
- Takes a packed hex value plus per-digit decimal-point and blank masks. Scans one digit at a time at a programmable rate.
- Double-buffers input data so the display never tears mid-frame.
- Sits between measurement/formatting logic (e.g. temperature BCD) and board display pins.

Parameters:
- N_DIGITS, 8, number of digits scanned; legal range 1..16.
- TICK_DIV, 100000, clk cycles each digit stays lit; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value_in  in  4*N_DIGITS  hex nibble per digit; nibble i is bits [4i+3:4i]; digit 0 is rightmost
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  N_DIGITS  force digit dark, 1 = blank
- load  in  1  one-cycle strobe capturing value_in/dp_in/blank_in into staging
- enable  in  1  0 = all anodes off; scanning continues
- seg_out  out  7  active-low segments, bit0 = a ... bit6 = g
- dp_out  out  1  active-low decimal point
- an_out  out  N_DIGITS  active-low anode enables, one-hot-low while lit
- frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Interface (already decided): one clock, clk. rst is synchronous and active-high. Everything is sampled on the rising edge of clk.
- Reset values:
  - seg_out = 7'h7F, dp_out = 1, an_out = all ones, frame_done = 0.
  - div counter = 0, digit index = 0.
  - staging, shadow and pending = 0.
- Divider: cnt counts 0..TICK_DIV-1, then wraps to 0. When cnt == TICK_DIV-1:
  - idx advances, wrapping N_DIGITS-1 -> 0.
  - If idx was N_DIGITS-1, the frame boundary occurs.
- Frame boundary, same cycle:
  - frame_done = 1 on the next cycle, for exactly 1 cycle.
  - If pending, shadow <= staging and pending <= 0.
- Load:
  - load = 1 writes staging from the inputs and sets pending.
  - A new load before the boundary overwrites staging; last write wins.
  - Load on the boundary cycle itself: shadow takes the old staging contents. The new data stays in staging with pending = 1 and applies at the next boundary.
- Digit decode:
  - Nibble shadow[idx] goes through the standard hex pattern table (0 = 7'b1000000 ... F = 7'b0001110).
  - dp_out = ~shadow_dp[idx].
- Output registration:
  - seg_out, dp_out and an_out are registered; they reflect idx with 1 cycle of latency.
  - an_out = ~(1 << idx) when enable is 1 and the digit is not blanked; otherwise all ones.
  - A blanked digit also drives seg_out = 7'h7F and dp_out = 1.
- enable = 0: cnt, idx and buffer update keep running. Only the outputs are forced dark.
- N_DIGITS = 1: idx is constant 0, and every wrap is a frame boundary.
- rst mid-frame: all state returns to reset values on the next edge. Pending data is discarded.

Optional Feature:
- Macro: SS_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: digit i (i > 0) is blanked when shadow nibbles i..N_DIGITS-1 are all zero and none of dp i..N-1 is set. Digit 0 is never auto-blanked. This OR's with blank_in.
- Undefined: only blank_in blanks; zeros are displayed.

Decomposition:
- Package ss_pkg:
  - SEG_W = 7.
  - Constant SEG_OFF = 7'h7F.
  - 16-entry hex segment table constant.
  - Function for idx width: max(1, $clog2(N_DIGITS)).
- Sub-module ss_hex_decode: combinational 4-bit to 7-bit lookup using the package table, instantiated once on the muxed nibble.

Test Plan (N_DIGITS=4, TICK_DIV=4 unless noted):
- Reset held 3 cycles then released -> an_out = 4'hF, seg_out = 7'h7F, dp_out = 1 during reset. First lit digit is 0, an_out = 4'b1110.
- load value_in = 16'h1234, enable = 1 -> after the next boundary, seg_out shows 4 (7'b0011001) with an_out = 1110, 3 with 1101, 2 with 1011, 1 with 0111. Each lasts 4 cycles; frame_done pulses every 16 cycles.
- Tear check: load 16'hAAAA mid-frame, then 16'h5555 two cycles later -> the rest of the current frame shows the old data; the next frame shows only 5 (7'b0010010).
- blank_in = 4'b0100, dp_in = 4'b0001, enable toggled 0 -> digit 2 gives an_out = 1111 in its slot. Digit 0 gives dp_out = 0. enable = 0 gives an_out = 1111 throughout while frame_done keeps pulsing.
- Load on the exact boundary cycle -> shadow keeps the old staging; the new value appears one frame later.
- With SS_SCAN_LEADING_ZERO_BLANK_EN, load 16'h0070 -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 -> only digit 0 lit, showing 0.
